// File: rtl/io_button_pkg.sv
// Shared IO address map and small helpers for the button block.
package io_button_pkg;

  // IO word addresses (byte address bits [15:2])
  localparam logic [13:0] IO_LED_ADR       = 14'h3F80;
  localparam logic [13:0] IO_BTN_STATE_ADR = 14'h3F84;
  localparam logic [13:0] IO_BTN_EDGE_ADR  = 14'h3F85;
  localparam logic [13:0] IO_BTN_CTRL_ADR  = 14'h3F86;

  // Register selected by a bus access
  typedef enum logic [1:0] {
    SEL_STATE,
    SEL_EDGE,
    SEL_CTRL,
    SEL_NONE
  } btn_sel_e;

  // Map a word address onto one of the button registers
  function automatic btn_sel_e btn_decode(input logic [13:0] adr);
    case (adr)
      IO_BTN_STATE_ADR: return SEL_STATE;
      IO_BTN_EDGE_ADR:  return SEL_EDGE;
      IO_BTN_CTRL_ADR:  return SEL_CTRL;
      default:          return SEL_NONE;
    endcase
  endfunction

  // A limit of zero behaves like one: stable follows sync a cycle later
  function automatic logic [15:0] eff_limit(input logic [15:0] lim);
    return (lim == 16'd0) ? 16'd1 : lim;
  endfunction

endpackage

// File: rtl/io_btn_debounce.sv
// One button: 2-flop synchronizer, polarity fix-up and stable-count debouncer.
module io_btn_debounce
  import io_button_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pin,
  input  logic [15:0] limit,
  output logic        stable
);

  logic        sync_1;
  logic        sync_2;
  logic        sync_n;
  logic [15:0] cnt;

  // Pressed-high view of the synchronized pin
  assign sync_n = ACTIVE_LOW ? ~sync_2 : sync_2;

  // Synchronize the pin and accept a new level only after it has held for limit cycles
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked branch
    // rather than in the sensitivity list.
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      stable <= 1'b0;
      cnt    <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments keep sync_2 taking the old sync_1,
      // which is what makes this a two-stage synchronizer.
      sync_1 <= pin;
      sync_2 <= sync_1;
      if (sync_n == stable) begin
        cnt <= 16'd0;
      end else if (cnt >= limit - 16'd1) begin
        // >= also commits promptly if the limit was lowered below the running count,
        // so the counter can never run past the limit and wrap.
        stable <= sync_n;
        cnt    <= 16'd0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/io_button.sv
// Memory-mapped button block: debounced state, press-pending flags with
// write-1-to-clear, per-button interrupt enables and a chained read port.
module io_button
  import io_button_pkg::*;
#(
  parameter int unsigned NBTN       = 4,
  parameter logic [15:0] DB_DEFAULT = 16'd50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dma_io_we,
  input  logic [13:0]     dma_io_wadr,
  input  logic [31:0]     dma_io_wdata,
  input  logic [13:0]     dma_io_radr,
  input  logic            dma_io_radr_en,
  input  logic [31:0]     dma_io_rdata_in,
  output logic [31:0]     dma_io_rdata,
  input  logic [NBTN-1:0] btn_in,
  output logic            btn_irq
);

  logic [NBTN-1:0] stable;
  logic [NBTN-1:0] stable_q;
  logic [NBTN-1:0] pend;
  logic [NBTN-1:0] ie;
  logic [NBTN-1:0] rise;
  logic [NBTN-1:0] clr;
  logic [15:0]     db_limit;
  logic [15:0]     limit;
  btn_sel_e        wsel;
  btn_sel_e        rsel;
  logic [31:0]     rd_mux;
  logic [31:0]     rd_data;
  logic            rd_hit;
  logic            unused_ok;

  // Upper write-data bits beyond the implemented fields are deliberately ignored
  assign unused_ok = &{1'b0, dma_io_wdata};

  assign limit = eff_limit(db_limit);

  for (genvar i = 0; i < NBTN; i++) begin : g_db
    io_btn_debounce #(
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .pin   (btn_in[i]),
      .limit (limit),
      .stable(stable[i])
    );
  end

  // Address decode, press detection, W1C mask and read mux
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held,
    // which would otherwise infer a latch.
    wsel   = dma_io_we      ? btn_decode(dma_io_wadr) : SEL_NONE;
    rsel   = dma_io_radr_en ? btn_decode(dma_io_radr) : SEL_NONE;
    rise   = stable & ~stable_q;
    clr    = (wsel == SEL_EDGE) ? dma_io_wdata[NBTN-1:0] : '0;
    rd_mux = '0;
    case (rsel)
      SEL_STATE: rd_mux[NBTN-1:0] = stable;
      SEL_EDGE:  rd_mux[NBTN-1:0] = pend;
      SEL_CTRL: begin
        rd_mux[15:0]     = db_limit;
        rd_mux[16+:NBTN] = ie;
      end
      default:   rd_mux = '0;
    endcase
  end

  // Control/status registers and the registered interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      pend     <= '0;
      ie       <= '0;
      db_limit <= DB_DEFAULT;
      btn_irq  <= 1'b0;
    end else begin
      stable_q <= stable;
      // A new press in the same cycle as its clear wins
      pend     <= (pend & ~clr) | rise;
      if (wsel == SEL_CTRL) begin
        db_limit <= dma_io_wdata[15:0];
        ie       <= dma_io_wdata[16+:NBTN];
      end
      btn_irq  <= |(pend & ie);
    end
  end

  // Capture read data at the request cycle; it is presented the cycle after
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_hit  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_hit  <= (rsel != SEL_NONE);
      rd_data <= rd_mux;
    end
  end

  // Chain pass-through unless this block owns the current read slot
  assign dma_io_rdata = (rd_hit && !rst) ? rd_data : dma_io_rdata_in;

endmodule

// File: tb/tb_io_button.sv
// Directed bench for io_button: reads push expected data into a scoreboard,
// a monitor pops and compares when the read data is presented.
module tb_io_button;
  import io_button_pkg::*;

  localparam int NBTN = 4;

  logic            clk;
  logic            rst;
  logic            dma_io_we;
  logic [13:0]     dma_io_wadr;
  logic [31:0]     dma_io_wdata;
  logic [13:0]     dma_io_radr;
  logic            dma_io_radr_en;
  logic [31:0]     dma_io_rdata_in;
  logic [31:0]     dma_io_rdata;
  logic [NBTN-1:0] btn_in;
  logic            btn_irq;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        req_q;

  io_button #(
    .NBTN      (NBTN),
    .DB_DEFAULT(16'd50000),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .dma_io_we      (dma_io_we),
    .dma_io_wadr    (dma_io_wadr),
    .dma_io_wdata   (dma_io_wdata),
    .dma_io_radr    (dma_io_radr),
    .dma_io_radr_en (dma_io_radr_en),
    .dma_io_rdata_in(dma_io_rdata_in),
    .dma_io_rdata   (dma_io_rdata),
    .btn_in         (btn_in),
    .btn_irq        (btn_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] adr, input logic [31:0] data);
    dma_io_we    = 1'b1;
    dma_io_wadr  = adr;
    dma_io_wdata = data;
    tick(1);
    dma_io_we    = 1'b0;
  endtask

  // Issue a read; the expected value is queued for the monitor
  task automatic rd(input string name, input logic [13:0] adr, input logic [31:0] exp);
    dma_io_radr_en = 1'b1;
    dma_io_radr    = adr;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick(1);
    dma_io_radr_en = 1'b0;
  endtask

  // Monitor: read data is valid in the cycle after the request was sampled
  always @(posedge clk) req_q <= dma_io_radr_en;

  always @(negedge clk) begin
    if (req_q === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, dma_io_rdata, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst             = 1'b1;
    dma_io_we       = 1'b0;
    dma_io_wadr     = '0;
    dma_io_wdata    = '0;
    dma_io_radr     = '0;
    dma_io_radr_en  = 1'b0;
    dma_io_rdata_in = 32'hA;
    btn_in          = 4'hF;
    tick(3);
    check("rdata_in_reset", dma_io_rdata, 32'hA);
    rst = 1'b0;

    // Reset values and chain pass-through
    check("irq_reset", {31'd0, btn_irq}, 32'd0);
    rd("ctrl_reset",  IO_BTN_CTRL_ADR,  32'h0000_C350);
    rd("state_reset", IO_BTN_STATE_ADR, 32'h0);
    rd("edge_reset",  IO_BTN_EDGE_ADR,  32'h0);
    rd("led_pass",    IO_LED_ADR,       32'hA);
    tick(1);
    check("idle_pass", dma_io_rdata, 32'hA);

    // Held press on bit 0, limit 4: stable rises exactly 6 edges after the pin
    wr(IO_BTN_CTRL_ADR, 32'h4);
    tick(2);
    btn_in[0] = 1'b0;
    tick(5);
    rd("state_before_6", IO_BTN_STATE_ADR, 32'h0);
    rd("state_at_6",     IO_BTN_STATE_ADR, 32'h1);
    rd("edge_press0",    IO_BTN_EDGE_ADR,  32'h1);

    // 3-cycle glitch on bit 1 is rejected
    btn_in[1] = 1'b0;
    tick(3);
    btn_in[1] = 1'b1;
    tick(10);
    rd("state_glitch", IO_BTN_STATE_ADR, 32'h1);
    rd("edge_glitch",  IO_BTN_EDGE_ADR,  32'h1);

    // W1C of one bit, then a clear colliding with a new press
    btn_in[1] = 1'b0;
    tick(10);
    rd("edge_both", IO_BTN_EDGE_ADR, 32'h3);
    wr(IO_BTN_EDGE_ADR, 32'h1);
    rd("edge_w1c", IO_BTN_EDGE_ADR, 32'h2);
    btn_in[0] = 1'b1;
    tick(10);
    btn_in[0] = 1'b0;
    tick(6);
    wr(IO_BTN_EDGE_ADR, 32'h1);
    rd("edge_set_wins", IO_BTN_EDGE_ADR, 32'h3);
    check("irq_ie_off", {31'd0, btn_irq}, 32'd0);

    // Interrupt path with ie=3, limit 8
    wr(IO_BTN_EDGE_ADR, 32'hF);
    btn_in[1] = 1'b1;
    tick(12);
    wr(IO_BTN_CTRL_ADR, 32'h0003_0008);
    rd("ctrl_rb", IO_BTN_CTRL_ADR, 32'h0003_0008);
    check("irq_idle", {31'd0, btn_irq}, 32'd0);
    btn_in[1] = 1'b0;
    tick(11);
    check("irq_pend_cycle", {31'd0, btn_irq}, 32'd0);
    tick(1);
    check("irq_set", {31'd0, btn_irq}, 32'd1);
    wr(IO_BTN_EDGE_ADR, 32'h2);
    check("irq_clr_cycle", {31'd0, btn_irq}, 32'd1);
    tick(1);
    check("irq_clr", {31'd0, btn_irq}, 32'd0);

    // Non-matching write ignored; same-cycle read/write returns old value
    wr(14'h3F87, 32'hFFFF_FFFF);
    rd("ctrl_nomatch", IO_BTN_CTRL_ADR, 32'h0003_0008);
    dma_io_we    = 1'b1;
    dma_io_wadr  = IO_BTN_CTRL_ADR;
    dma_io_wdata = 32'h0000_0008;
    rd("ctrl_rw_old", IO_BTN_CTRL_ADR, 32'h0003_0008);
    dma_io_we    = 1'b0;
    rd("ctrl_rw_new", IO_BTN_CTRL_ADR, 32'h0000_0008);

    // Limit 0: stable follows sync one cycle later
    wr(IO_BTN_CTRL_ADR, 32'h0);
    btn_in[2] = 1'b0;
    tick(2);
    rd("state_lim0_pre",  IO_BTN_STATE_ADR, 32'h3);
    rd("state_lim0_post", IO_BTN_STATE_ADR, 32'h7);

    // Reset mid-count, button held through reset
    wr(IO_BTN_CTRL_ADR, 32'h10);
    btn_in[3] = 1'b0;
    tick(6);
    rst = 1'b1;
    tick(1);
    check("rdata_in_rst", dma_io_rdata, 32'hA);
    tick(1);
    check("irq_rst", {31'd0, btn_irq}, 32'd0);
    rst = 1'b0;
    rd("ctrl_post_rst",  IO_BTN_CTRL_ADR,  32'h0000_C350);
    rd("state_post_rst", IO_BTN_STATE_ADR, 32'h0);
    rd("edge_post_rst",  IO_BTN_EDGE_ADR,  32'h0);
    wr(IO_BTN_CTRL_ADR, 32'h4);
    tick(12);
    rd("state_held", IO_BTN_STATE_ADR, 32'hF);
    rd("edge_held",  IO_BTN_EDGE_ADR,  32'hF);

    tick(3);
    check("sb_drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_button.md
IO_BUTTON -- requirements
Module: io_button

Interface
REQ-001 Parameter NBTN, default 4, number of button inputs (1..16).
REQ-002 Parameter DB_DEFAULT, default 16'd50000, debounce stable-count loaded at reset.
REQ-003 Parameter ACTIVE_LOW, default 1, 1 = pin low means pressed.
REQ-004 clk  in  1  single system clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 dma_io_we  in  1  IO bus write strobe.
REQ-007 dma_io_wadr  in  14 [15:2]  IO bus word write address.
REQ-008 dma_io_wdata  in  32  IO bus write data.
REQ-009 dma_io_radr  in  14 [15:2]  IO bus word read address.
REQ-010 dma_io_radr_en  in  1  IO bus read request.
REQ-011 dma_io_rdata_in  in  32  read data from upstream IO slave in the chain.
REQ-012 dma_io_rdata  out  32  read data to next slave in the chain / bus master.
REQ-013 btn_in  in  NBTN  raw asynchronous button pins.
REQ-014 btn_irq  out  1  level interrupt, pending-and-enabled press.

Function
REQ-015 Register map (word addresses): BTN_STATE 14'h3F84 RO; BTN_EDGE 14'h3F85 RW1C; BTN_CTRL 14'h3F86 RW.
REQ-016 BTN_STATE read value = {zeros, stable[NBTN-1:0]}, 1 = pressed.
REQ-017 BTN_EDGE read value = {zeros, pend[NBTN-1:0]}; write 1 to a bit clears it, 0 leaves it unchanged.
REQ-018 BTN_CTRL = {zeros, ie[NBTN-1:0] at [16+NBTN-1:16], db_limit[15:0]}; written whole-word on hit.
REQ-019 btn_in passes through a 2-flop synchronizer, then is inverted when ACTIVE_LOW=1, giving sync_n.
REQ-020 Per bit: sync == stable -> counter cleared to 0.
REQ-021 Per bit: sync != stable -> counter increments; at counter == eff_limit-1, stable <= sync and counter <= 0 in the same cycle.
REQ-022 eff_limit = db_limit, except db_limit 0 is treated as 1 (stable follows sync with 1-cycle latency).
REQ-023 Counter is 16-bit and never wraps; a bounce back to stable value before limit restarts from 0.
REQ-024 A 0->1 transition of stable[i] sets pend[i] on the next edge.
REQ-025 Same-cycle set and W1C clear of pend[i]: set wins, pend[i] stays 1.
REQ-026 A write to BTN_CTRL changing db_limit does not reset in-progress counters; the new limit applies from the next cycle.
REQ-027 btn_irq = |(pend & ie), registered, 1-cycle delay after pend/ie update.
REQ-028 Read hit = dma_io_radr_en and radr equal to one of the three addresses; the selected register value is captured into a 32-bit read register at the request cycle.
REQ-029 dma_io_rdata = the captured value in the cycle after a hit; otherwise dma_io_rdata_in passes through combinationally.
REQ-030 Reads have no side effects; BTN_EDGE read does not clear pend.
REQ-031 Writes to non-matching addresses and reads of write-only bits have no effect / return 0.
REQ-032 Simultaneous read and write to the same register in one cycle: the read returns the pre-write value.

Reset
REQ-033 On rst: sync flops, stable, counters, pend = 0; ie = 0; db_limit = DB_DEFAULT; read-hit flag and read register = 0; btn_irq = 0.
REQ-034 rst asserted mid-debounce discards the count; a button held through reset is reported as a press (pend set) once the debounce completes after reset.
REQ-035 During rst, dma_io_rdata = dma_io_rdata_in.

Structure
REQ-036 The three register address defines go into the shared IO address include, alongside the existing LED address 14'h3F80.
REQ-037 One sub-module io_btn_debounce (synchronizer + counter + stable, 1 bit) is instantiated NBTN times; decode, pend, ie, irq and read mux live in io_button.

Verification
REQ-038 db_limit=4, btn_in[0] driven low (pressed) and held -> stable[0]=1 exactly 2+4 cycles after the pin edge, pend=4'b0001, BTN_STATE read returns 32'h1.
REQ-039 db_limit=4, pulse btn_in[1] low for 3 cycles then high -> stable and pend remain 0.
REQ-040 pend=4'b0011, write 32'h1 to BTN_EDGE -> pend=4'b0010; same-cycle new press on bit 0 with clear -> pend bit 0 stays 1.
REQ-041 Write 32'h0003_0008 to BTN_CTRL, press bit 1 -> btn_irq=1 one cycle after pend[1] is set; clearing pend[1] -> btn_irq=0 one cycle later.
REQ-042 Read 14'h3F80 with dma_io_rdata_in=32'hA -> dma_io_rdata=32'hA; read 14'h3F86 after reset -> 32'h0000_C350 one cycle later.
REQ-043 Write 32'h0 to BTN_CTRL, toggle pin -> stable follows sync with 1-cycle latency; rst asserted mid-count -> all state returns to REQ-033 values.
